prog_delay_timer: RTL and testbench



---
 rtl/prog_delay_timer.sv | 89 ++++++++
 tb/tb_prog_delay_timer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prog_delay_timer.sv
// Programmable tick-counting delay timer with one-shot/periodic modes, start/stop control,
// latched terminal count, and registered timeout/err pulses one cycle after the detecting edge.
module prog_delay_timer #(
  parameter int N_BITS = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [N_BITS-1:0] N,
  output logic              timeout,
  output logic              busy,
  output logic [N_BITS-1:0] remaining,
  output logic              err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [N_BITS-1:0] count_q, count_d;
  logic [N_BITS-1:0] n_lat_q, n_lat_d;
  logic              mode_lat_q, mode_lat_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic              start_ok;
  logic              terminal;

  assign start_ok = start && (N != '0);
  assign terminal = (count_q == n_lat_q - N_BITS'(1));

  // Priority: stop > accepted start > tick; a rejected start still lets the run count.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    n_lat_d    = n_lat_q;
    mode_lat_d = mode_lat_q;
    timeout_d  = 1'b0;
    err_d      = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start_ok) begin
      state_d    = RUN;
      count_d    = '0;
      n_lat_d    = N;
      mode_lat_d = mode;
    end else begin
      err_d = start;
      if (state_q == RUN && tick) begin
        if (terminal) begin
          timeout_d = 1'b1;
          count_d   = '0;
          if (!mode_lat_q) begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + N_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      n_lat_q    <= '0;
      mode_lat_q <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      n_lat_q    <= n_lat_d;
      mode_lat_q <= mode_lat_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
    end
  end

  assign timeout   = timeout_q;
  assign err       = err_q;
  assign busy      = (state_q == RUN);
  assign remaining = (state_q == RUN) ? (n_lat_q - count_q) : '0;

endmodule

// File: tb/tb_prog_delay_timer.sv
// Scoreboard bench for prog_delay_timer: a down-counting reference model pushes expected
// outputs per cycle; directed constants check timeout/err counts per scenario.
module tb_prog_delay_timer;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst, tick, start, stop, mode;
  logic [W-1:0] n;
  logic         timeout, busy, err;
  logic [W-1:0] remaining;

  always #5 clk = ~clk;

  prog_delay_timer #(.N_BITS(W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .mode(mode),
    .N(n), .timeout(timeout), .busy(busy), .remaining(remaining), .err(err)
  );

  typedef struct packed {
    logic         timeout;
    logic         busy;
    logic         err;
    logic [W-1:0] rem;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int to_cnt = 0;
  int err_cnt = 0;

  logic         m_run, m_per;
  logic [W-1:0] m_left, m_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic cyc(input logic r, input logic tk, input logic st, input logic sp,
                     input logic md, input logic [W-1:0] nv);
    obs_t e, g;
    rst = r; tick = tk; start = st; stop = sp; mode = md; n = nv;
    e = '0;
    if (r) begin
      m_run = 0; m_per = 0; m_left = '0; m_n = '0;
    end else if (sp) begin
      m_run = 0; m_left = '0;
    end else if (st && nv != '0) begin
      m_run = 1; m_per = md; m_left = nv; m_n = nv;
    end else begin
      if (st) e.err = 1'b1;
      if (m_run && tk) begin
        if (m_left == W'(1)) begin
          e.timeout = 1'b1;
          if (m_per) m_left = m_n;
          else begin
            m_run = 0; m_left = '0;
          end
        end else begin
          m_left = m_left - W'(1);
        end
      end
    end
    e.busy = m_run;
    e.rem  = m_run ? m_left : '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = {timeout, busy, err, remaining};
    if (g.timeout) to_cnt++;
    if (g.err) err_cnt++;
    e = exp_q.pop_front();
    check_val("outputs", 32'(g), 32'(e));
  endtask

  task automatic ticks(input int k, input logic tk);
    for (int i = 0; i < k; i++) cyc(0, tk, 0, 0, 0, '0);
  endtask

  initial begin
    rst = 1; tick = 0; start = 0; stop = 0; mode = 0; n = '0;
    cyc(1, 1, 1, 0, 1, W'(5));
    cyc(1, 0, 0, 0, 0, '0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_rem", 32'(remaining), 32'd0);

    // One-shot N=5, tick held high including the start edge
    to_cnt = 0;
    cyc(0, 1, 1, 0, 0, W'(5));
    check_val("os_rem_start", 32'(remaining), 32'd5);
    ticks(4, 1);
    check_val("os_rem_4", 32'(remaining), 32'd1);
    check_val("os_no_to_early", 32'(to_cnt), 32'd0);
    ticks(1, 1);
    check_val("os_to", 32'(timeout), 32'd1);
    check_val("os_busy_fall", 32'(busy), 32'd0);
    ticks(6, 1);
    check_val("os_to_count", 32'(to_cnt), 32'd1);

    // Periodic N=3, tick every other cycle
    to_cnt = 0;
    cyc(0, 0, 1, 0, 1, W'(3));
    for (int i = 0; i < 10; i++) begin
      ticks(1, 1);
      ticks(1, 0);
    end
    check_val("per_to_count", 32'(to_cnt), 32'd3);
    check_val("per_busy", 32'(busy), 32'd1);
    check_val("per_rem", 32'(remaining), 32'd2);
    cyc(0, 0, 0, 1, 0, '0);

    // Stop coincident with terminal tick suppresses timeout
    to_cnt = 0;
    cyc(0, 0, 1, 0, 1, W'(4));
    ticks(3, 1);
    cyc(0, 1, 0, 1, 0, '0);
    check_val("stop_to_count", 32'(to_cnt), 32'd0);
    check_val("stop_busy", 32'(busy), 32'd0);
    check_val("stop_rem", 32'(remaining), 32'd0);
    cyc(0, 0, 1, 0, 0, W'(2));
    ticks(2, 1);
    check_val("after_stop_to", 32'(to_cnt), 32'd1);

    // Zero-count start: idle and during a run
    err_cnt = 0; to_cnt = 0;
    cyc(0, 0, 1, 0, 0, '0);
    check_val("err_idle", 32'(err), 32'd1);
    check_val("err_idle_busy", 32'(busy), 32'd0);
    ticks(1, 0);
    check_val("err_single", 32'(err), 32'd0);
    cyc(0, 0, 1, 0, 0, W'(6));
    ticks(2, 1);
    cyc(0, 1, 1, 0, 1, '0);
    ticks(2, 1);
    check_val("err_run_no_to", 32'(to_cnt), 32'd0);
    ticks(1, 1);
    check_val("err_run_to", 32'(to_cnt), 32'd1);
    check_val("err_count", 32'(err_cnt), 32'd2);

    // Restart mid-run, then start+stop together
    to_cnt = 0;
    cyc(0, 0, 1, 0, 0, W'(10));
    ticks(7, 1);
    cyc(0, 1, 1, 0, 0, W'(3));
    ticks(2, 1);
    check_val("restart_no_to", 32'(to_cnt), 32'd0);
    ticks(1, 1);
    check_val("restart_to", 32'(to_cnt), 32'd1);
    cyc(0, 0, 1, 1, 0, W'(5));
    check_val("start_stop_idle", 32'(busy), 32'd0);

    // Reset during a run
    to_cnt = 0;
    cyc(0, 0, 1, 0, 1, W'(4));
    ticks(2, 1);
    check_val("pre_rst_rem", 32'(remaining), 32'd2);
    cyc(1, 1, 0, 0, 0, '0);
    check_val("rst_run_outs", 32'({timeout, busy, err, remaining}), 32'd0);
    ticks(6, 1);
    check_val("rst_no_to", 32'(to_cnt), 32'd0);

    // N=1 periodic: a pulse per tick
    to_cnt = 0;
    cyc(0, 1, 1, 0, 1, W'(1));
    ticks(5, 1);
    check_val("n1_to_count", 32'(to_cnt), 32'd5);
    cyc(0, 0, 0, 1, 0, '0);

    // Maximum count
    to_cnt = 0;
    cyc(0, 0, 1, 0, 0, W'(127));
    check_val("max_rem", 32'(remaining), 32'd127);
    ticks(126, 1);
    check_val("max_no_to", 32'(to_cnt), 32'd0);
    ticks(1, 1);
    check_val("max_to", 32'(timeout), 32'd1);
    ticks(3, 1);
    check_val("max_to_count", 32'(to_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
